// File: rtl/logic_pkg.sv
// Shared types and elaboration helpers for the align_seq normalizer.
// The package holds the state encoding and the width/pass-count derivations.
package logic_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int f_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int f_cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/align.sv
// Window align unit: counts leading zeros in the top 2^ORDER bits of a word
// and shifts the word left by that amount (at most 2^ORDER bits per use).
module align
    import logic_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int W     = 32
) (
    input  logic [W-1:0]   i_data,
    output logic [W-1:0]   o_data,
    output logic [ORDER:0] o_count
);
    localparam int HW   = 1 << ORDER;
    localparam int CNTW = ORDER + 1;

    logic [HW-1:0] w_win;
    assign w_win = i_data[W-1 -: HW];

    // Scan upward so the highest set bit is the last to write the count.
    always_comb begin
        o_count = CNTW'(HW);
        for (int i = 0; i < HW; i++)
            if (w_win[i]) o_count = CNTW'(HW - 1 - i);
    end

    assign o_data = i_data << o_count;

endmodule

// File: rtl/align_seq.sv
// Multi-cycle leading-zero normalizer built around one narrow align window.
// Optional ALIGN_SEQ_LIMIT_EN adds a `limit` port capping the total shift.
module align_seq
    import logic_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int W     = 32,
    localparam int CW   = f_clog2(W + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in,
`ifdef ALIGN_SEQ_LIMIT_EN
    input  logic [CW-1:0] limit,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out,
    output logic [CW-1:0] count,
    output logic          zero
);
    localparam int HW = 1 << ORDER;
    localparam int P  = f_cdiv(W, HW);
    localparam int PW = (P > 1) ? f_clog2(P) : 1;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_acc, w_acc_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_pass, w_pass_nxt;
    logic          r_zero, w_zero_nxt;

    logic [W-1:0]  w_al_out;
    logic [ORDER:0] w_al_cnt;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_sum_sat;

    align #(.ORDER(ORDER), .W(W)) u_align (
        .i_data  (r_acc),
        .o_data  (w_al_out),
        .o_count (w_al_cnt)
    );

    assign w_sum     = {1'b0, r_cnt} + (CW+1)'(w_al_cnt);
    assign w_sum_sat = (w_sum > (CW+1)'(W)) ? CW'(W) : w_sum[CW-1:0];

`ifdef ALIGN_SEQ_LIMIT_EN
    logic [CW-1:0] r_lim, w_lim_nxt;
    logic          w_lim_hit;
    assign w_lim_hit = ({1'b0, r_lim} <= w_sum);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_pass_nxt  = r_pass;
        w_zero_nxt  = r_zero;
`ifdef ALIGN_SEQ_LIMIT_EN
        w_lim_nxt   = r_lim;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_acc_nxt  = in;
                    w_cnt_nxt  = '0;
                    w_pass_nxt = '0;
                    w_zero_nxt = 1'b0;
`ifdef ALIGN_SEQ_LIMIT_EN
                    w_lim_nxt  = limit;
`endif
                    if (in == '0) begin
                        w_zero_nxt  = 1'b1;
`ifdef ALIGN_SEQ_LIMIT_EN
                        w_cnt_nxt   = (limit > CW'(W)) ? CW'(W) : limit;
`else
                        w_cnt_nxt   = CW'(W);
`endif
                        w_state_nxt = S_DONE;
                    end
`ifdef ALIGN_SEQ_LIMIT_EN
                    else if (limit == '0) begin
                        w_state_nxt = S_DONE;
                    end
`endif
                    else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_pass_nxt = r_pass + 1'b1;
                w_acc_nxt  = w_al_out;
                w_cnt_nxt  = w_sum_sat;
`ifdef ALIGN_SEQ_LIMIT_EN
                // Residual shift stops exactly at the limit; cnt never exceeds r_lim.
                if (w_lim_hit) begin
                    w_acc_nxt   = r_acc << (r_lim - r_cnt);
                    w_cnt_nxt   = r_lim;
                    w_state_nxt = S_DONE;
                end else
`endif
                if (w_al_cnt < (ORDER+1)'(HW)) begin
                    w_state_nxt = S_DONE;
                end else if (r_pass == PW'(P - 1)) begin
                    w_cnt_nxt   = CW'(W);
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_pass  <= '0;
            r_zero  <= 1'b0;
`ifdef ALIGN_SEQ_LIMIT_EN
            r_lim   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pass  <= w_pass_nxt;
            r_zero  <= w_zero_nxt;
`ifdef ALIGN_SEQ_LIMIT_EN
            r_lim   <= w_lim_nxt;
`endif
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_acc;
    assign count     = r_cnt;
    assign zero      = r_zero;

endmodule

// File: tb/tb_align_seq.sv
// Directed bench for align_seq (W=32, ORDER=3): vector table plus hand-written
// backpressure and mid-operation reset sequences.
module tb_align_seq;
    localparam int W  = 32;
    localparam int CW = 6;

    logic          clock, reset;
    logic          in_valid, in_ready, out_valid, out_ready, zero;
    logic [W-1:0]  tb_in, out;
    logic [CW-1:0] count, limit;

    int errors = 0;
    int checks = 0;

    align_seq #(.ORDER(3), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (tb_in),
`ifdef ALIGN_SEQ_LIMIT_EN
        .limit     (limit),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .count     (count),
        .zero      (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0]  din;
        logic [CW-1:0] lim;
        logic [W-1:0]  eout;
        logic [CW-1:0] ecnt;
        logic          ezero;
        int            elat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operand and return the cycle offset at which out_valid showed.
    task automatic issue(input logic [W-1:0] d, input logic [CW-1:0] l, output int lat);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        tb_in    = d;
        limit    = l;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0]  hold_out;
        logic [CW-1:0] hold_cnt;

        vq.push_back('{32'h8000_0000, 6'd32, 32'h8000_0000, 6'd0,  1'b0, 2});
        vq.push_back('{32'h0000_0001, 6'd32, 32'h8000_0000, 6'd31, 1'b0, 5});
        vq.push_back('{32'h0010_0000, 6'd32, 32'h8000_0000, 6'd11, 1'b0, 3});
        vq.push_back('{32'h0000_0000, 6'd32, 32'h0000_0000, 6'd32, 1'b1, 1});
        vq.push_back('{32'h0000_00F0, 6'd32, 32'hF000_0000, 6'd24, 1'b0, 5});
        vq.push_back('{32'h00FF_0000, 6'd32, 32'hFF00_0000, 6'd8,  1'b0, 3});
        vq.push_back('{32'h0100_0000, 6'd32, 32'h8000_0000, 6'd7,  1'b0, 2});
`ifdef ALIGN_SEQ_LIMIT_EN
        vq.push_back('{32'h0000_0001, 6'd10, 32'h0000_0400, 6'd10, 1'b0, 3});
        vq.push_back('{32'h0000_0000, 6'd40, 32'h0000_0000, 6'd32, 1'b1, 1});
        vq.push_back('{32'h0000_1234, 6'd0,  32'h0000_1234, 6'd0,  1'b0, 1});
`endif

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tb_in = '0; limit = 6'd32;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out",       out,            32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        foreach (vq[i]) begin
            issue(vq[i].din, vq[i].lim, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vq[i].elat));
            chk($sformatf("v%0d_out", i), out, vq[i].eout);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].ecnt));
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vq[i].ezero));
            chk($sformatf("v%0d_in_ready_busy", i), 32'(in_ready), 32'd0);
            @(posedge clock); #1;
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(32'h0000_00F0, 6'd32, lat);
        chk("bp_latency", 32'(lat), 32'd5);
        hold_out = out;
        hold_cnt = count;
        chk("bp_out", hold_out, 32'hF000_0000);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_out", c), out, 32'hF000_0000);
            chk($sformatf("bp_hold%0d_count", c), 32'(count), 32'(hold_cnt));
            chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset during RUN: immediate return to idle, nothing emitted afterwards.
        in_valid = 1'b1; tb_in = 32'h0000_00F0; limit = 6'd32;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk("rr_running_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_in_ready",  32'(in_ready),  32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (out_valid) lat++;
        end
        chk("rr_no_result", 32'(lat), 32'd0);

        // Block still works after the aborted operation.
        issue(32'h0010_0000, 6'd32, lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_count", 32'(count), 32'd11);
        chk("post_rst_out", out, 32'h8000_0000);
        @(posedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
